// File: rtl/result_split.sv
// Serialises one packed result vector into a stream of 32-bit addressed words,
// LSB word first, with a one-cycle done pulse after the final word is taken.
module result_split #(
    parameter int CO     = 16,
    parameter int O_F_BW = 20,
    localparam int RES_BW = CO * O_F_BW,
    localparam int NW     = (RES_BW + 31) / 32,
    localparam int CW     = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [RES_BW-1:0] in_result,
    output logic              in_ready,
    output logic [31:0]       out_word,
    output logic [31:0]       out_address,
    output logic              out_enable,
    input  logic              out_ready,
    output logic              out_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [NW*32-1:0]  buffer_r;
    logic [NW*32-1:0]  capture_s;
    logic [CW-1:0]     cnt_r;
    logic              in_ready_r;
    logic              out_enable_r;
    logic              out_done_r;
    logic              last_s;

    // Zero-extend the incoming vector to a whole number of words.
    always_comb begin
        capture_s               = '0;
        capture_s[RES_BW-1:0]   = in_result;
    end

    // Flags the word currently presented as the final one of the vector.
    always_comb begin
        last_s = (cnt_r == CW'(NW - 1));
    end

    // Transfer sequencer: capture, shift out one word per handshake, pulse done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            buffer_r     <= '0;
            cnt_r        <= '0;
            in_ready_r   <= 1'b1;
            out_enable_r <= 1'b0;
            out_done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        buffer_r     <= capture_s;
                        cnt_r        <= '0;
                        state_r      <= SEND;
                        in_ready_r   <= 1'b0;
                        out_enable_r <= 1'b1;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        buffer_r <= buffer_r >> 32;
                        if (last_s) begin
                            cnt_r        <= '0;
                            state_r      <= DONE;
                            out_enable_r <= 1'b0;
                            out_done_r   <= 1'b1;
                        end else begin
                            cnt_r        <= cnt_r + CW'(1);
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    out_done_r   <= 1'b0;
                    in_ready_r   <= 1'b1;
                    out_enable_r <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    buffer_r     <= '0;
                    cnt_r        <= '0;
                    in_ready_r   <= 1'b1;
                    out_enable_r <= 1'b0;
                    out_done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_enable  = out_enable_r;
    assign out_done    = out_done_r;
    assign out_word    = buffer_r[31:0];
    assign out_address = {{(32-CW){1'b0}}, cnt_r};

endmodule

// File: tb/tb_result_split.sv
// Directed bench for result_split: default 16x20 instance plus a 3x20 padding
// instance and a single-word 1x20 instance.
module tb_result_split;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid;
    logic [319:0] in_result;
    logic         in_ready;
    logic [31:0]  out_word;
    logic [31:0]  out_address;
    logic         out_enable;
    logic         out_ready;
    logic         out_done;

    logic         in_valid2, in_ready2, out_enable2, out_ready2, out_done2;
    logic [59:0]  in_result2;
    logic [31:0]  out_word2, out_address2;

    logic         in_valid3, in_ready3, out_enable3, out_ready3, out_done3;
    logic [19:0]  in_result3;
    logic [31:0]  out_word3, out_address3;

    int checks   = 0;
    int failures = 0;

    logic [31:0] words [16];
    logic [31:0] addrs [16];

    result_split dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_result(in_result),
        .in_ready(in_ready), .out_word(out_word), .out_address(out_address),
        .out_enable(out_enable), .out_ready(out_ready), .out_done(out_done)
    );

    result_split #(.CO(3), .O_F_BW(20)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_result(in_result2),
        .in_ready(in_ready2), .out_word(out_word2), .out_address(out_address2),
        .out_enable(out_enable2), .out_ready(out_ready2), .out_done(out_done2)
    );

    result_split #(.CO(1), .O_F_BW(20)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_result(in_result3),
        .in_ready(in_ready3), .out_word(out_word3), .out_address(out_address3),
        .out_enable(out_enable3), .out_ready(out_ready3), .out_done(out_done3)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [319:0] make_vec(input int base);
        logic [319:0] v;
        v = '0;
        for (int c = 0; c < 16; c++) v[c*20 +: 20] = 20'(c + base);
        return v;
    endfunction

    function automatic logic [31:0] word_of(input logic [319:0] v, input int k);
        return v[32*k +: 32];
    endfunction

    task automatic do_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step; step;
        reset = 1'b0;
    endtask

    // Records accepted words; mode 0 = ready always, mode 1 = ready pattern 1,0,0.
    task automatic collect(input int mode, input int max_cyc, output int n,
                           output int stall_err, output bit got_done);
        bit          prev_stall;
        logic [31:0] pw, pa;
        n = 0; stall_err = 0; got_done = 1'b0; prev_stall = 1'b0;
        pw = '0; pa = '0;
        for (int c = 0; c < max_cyc; c++) begin
            out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (prev_stall && (out_word !== pw || out_address !== pa || out_enable !== 1'b1))
                stall_err++;
            if (out_done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (out_enable === 1'b1 && out_ready) begin
                if (n < 16) begin
                    words[n] = out_word;
                    addrs[n] = out_address;
                end
                n++;
            end
            prev_stall = (out_enable === 1'b1) && !out_ready;
            pw = out_word; pa = out_address;
            step;
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (in_ready !== 1'b1 || out_enable !== 1'b0 || out_done !== 1'b0 ||
            out_word !== 32'h0 || out_address !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b en=%b done=%b word=%h addr=%h required 1 0 0 0 0",
                     in_ready, out_enable, out_done, out_word, out_address);
        end
    endtask

    task automatic test_single;
        logic [319:0] v;
        int n, se; bit gd;
        do_reset;
        v = make_vec(1);
        in_result = v; in_valid = 1'b1; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        checks++;
        if (out_enable !== 1'b1 || out_word !== 32'h0020_0001 || out_address !== 32'd0) begin
            failures++;
            $display("FAIL single_word0: en=%b word=%h addr=%h required 1 00200001 0",
                     out_enable, out_word, out_address);
        end
        collect(0, 40, n, se, gd);
        checks++;
        if (n !== 10 || !gd) begin
            failures++;
            $display("FAIL single_count: words=%0d done=%b required 10 1", n, gd);
        end
        for (int k = 0; k < 10 && k < n; k++) begin
            checks++;
            if (addrs[k] !== 32'(k) || words[k] !== word_of(v, k)) begin
                failures++;
                $display("FAIL single_word%0d: addr=%0d word=%h required %0d %h",
                         k, addrs[k], words[k], k, word_of(v, k));
            end
        end
        checks++;
        if (out_enable !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_done_state: en=%b rdy=%b required 0 0", out_enable, in_ready);
        end
        step;
        checks++;
        if (out_done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_after_done: done=%b rdy=%b required 0 1", out_done, in_ready);
        end
    endtask

    task automatic test_backpressure;
        logic [319:0] v;
        int n, se; bit gd;
        do_reset;
        v = make_vec(7);
        in_result = v; in_valid = 1'b1; out_ready = 1'b0;
        step;
        in_valid = 1'b0;
        collect(1, 80, n, se, gd);
        checks++;
        if (n !== 10 || !gd || se !== 0) begin
            failures++;
            $display("FAIL bp_count: words=%0d done=%b stall_err=%0d required 10 1 0", n, gd, se);
        end
        for (int k = 0; k < 10 && k < n; k++) begin
            checks++;
            if (addrs[k] !== 32'(k) || words[k] !== word_of(v, k)) begin
                failures++;
                $display("FAIL bp_word%0d: addr=%0d word=%h required %0d %h",
                         k, addrs[k], words[k], k, word_of(v, k));
            end
        end
    endtask

    task automatic test_ignored_input;
        logic [319:0] a, b;
        int n, se; bit gd;
        do_reset;
        a = make_vec(1);
        b = make_vec(100);
        in_result = a; in_valid = 1'b1; out_ready = 1'b1;
        step;
        in_result = b;
        collect(0, 40, n, se, gd);
        checks++;
        if (n !== 10 || !gd) begin
            failures++;
            $display("FAIL ign_count: words=%0d done=%b required 10 1", n, gd);
        end
        for (int k = 0; k < 10 && k < n; k++) begin
            checks++;
            if (words[k] !== word_of(a, k)) begin
                failures++;
                $display("FAIL ign_word%0d: word=%h required %h", k, words[k], word_of(a, k));
            end
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ign_done_rdy: rdy=%b required 0", in_ready);
        end
        step;
        checks++;
        if (in_ready !== 1'b1 || out_enable !== 1'b0) begin
            failures++;
            $display("FAIL ign_idle: rdy=%b en=%b required 1 0", in_ready, out_enable);
        end
        step;
        in_valid = 1'b0;
        checks++;
        if (out_enable !== 1'b1 || out_word !== word_of(b, 0) || out_address !== 32'd0) begin
            failures++;
            $display("FAIL ign_capture_b: en=%b word=%h addr=%0d required 1 %h 0",
                     out_enable, out_word, out_address, word_of(b, 0));
        end
    endtask

    task automatic test_reset_mid;
        int seen_en, seen_done;
        do_reset;
        in_result = make_vec(3); in_valid = 1'b1; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step;
        checks++;
        if (out_address !== 32'd5 || out_enable !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: addr=%0d en=%b required 5 1", out_address, out_enable);
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        checks++;
        if (out_enable !== 1'b0 || out_done !== 1'b0 || in_ready !== 1'b1 ||
            out_address !== 32'd0 || out_word !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset: en=%b done=%b rdy=%b addr=%0d word=%h required 0 0 1 0 0",
                     out_enable, out_done, in_ready, out_address, out_word);
        end
        seen_en = 0; seen_done = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_enable === 1'b1) seen_en++;
            if (out_done === 1'b1) seen_done++;
            step;
        end
        checks++;
        if (seen_en !== 0 || seen_done !== 0) begin
            failures++;
            $display("FAIL mid_after: enable_cycles=%0d done_cycles=%0d required 0 0",
                     seen_en, seen_done);
        end
    endtask

    task automatic test_back_to_back;
        int acc [2];
        int na;
        do_reset;
        in_result = make_vec(1); in_valid = 1'b1; out_ready = 1'b1;
        na = 0;
        for (int c = 0; c < 40 && na < 2; c++) begin
            if (in_ready === 1'b1) begin
                acc[na] = c;
                na++;
            end
            step;
        end
        in_valid = 1'b0;
        checks++;
        if (na !== 2) begin
            failures++;
            $display("FAIL b2b_timeout: acceptances=%0d required 2", na);
        end else if (acc[1] - acc[0] !== 12) begin
            failures++;
            $display("FAIL b2b_gap: gap=%0d required 12", acc[1] - acc[0]);
        end
    endtask

    task automatic test_padding;
        do_reset;
        in_result2 = '1; in_valid2 = 1'b1; out_ready2 = 1'b1;
        step;
        in_valid2 = 1'b0;
        checks++;
        if (out_enable2 !== 1'b1 || out_word2 !== 32'hFFFF_FFFF || out_address2 !== 32'd0) begin
            failures++;
            $display("FAIL pad_word0: en=%b word=%h addr=%0d required 1 ffffffff 0",
                     out_enable2, out_word2, out_address2);
        end
        step;
        checks++;
        if (out_enable2 !== 1'b1 || out_word2 !== 32'h0FFF_FFFF || out_address2 !== 32'd1) begin
            failures++;
            $display("FAIL pad_word1: en=%b word=%h addr=%0d required 1 0fffffff 1",
                     out_enable2, out_word2, out_address2);
        end
        step;
        checks++;
        if (out_done2 !== 1'b1 || out_enable2 !== 1'b0) begin
            failures++;
            $display("FAIL pad_done: done=%b en=%b required 1 0", out_done2, out_enable2);
        end
    endtask

    task automatic test_single_word;
        do_reset;
        in_result3 = '1; in_valid3 = 1'b1; out_ready3 = 1'b1;
        step;
        in_valid3 = 1'b0;
        checks++;
        if (out_enable3 !== 1'b1 || out_word3 !== 32'h000F_FFFF || out_address3 !== 32'd0) begin
            failures++;
            $display("FAIL nw1_word: en=%b word=%h addr=%0d required 1 000fffff 0",
                     out_enable3, out_word3, out_address3);
        end
        step;
        checks++;
        if (out_done3 !== 1'b1 || out_enable3 !== 1'b0) begin
            failures++;
            $display("FAIL nw1_done: done=%b en=%b required 1 0", out_done3, out_enable3);
        end
        step;
        checks++;
        if (out_done3 !== 1'b0 || in_ready3 !== 1'b1) begin
            failures++;
            $display("FAIL nw1_idle: done=%b rdy=%b required 0 1", out_done3, in_ready3);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_result = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; in_result2 = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b0; in_result3 = '0;
        test_reset;
        test_single;
        test_backpressure;
        test_ignored_input;
        test_reset_mid;
        test_back_to_back;
        test_padding;
        test_single_word;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_split.md
RESULT_SPLIT -- requirements
Module: result_split

Interface
REQ-001 Parameter CO, default 16, number of output channels per result vector.
REQ-002 Parameter O_F_BW, default 20, bits per output-channel value.
REQ-003 Derived constants: RES_BW = CO*O_F_BW (default 320), NW = ceil(RES_BW/32) (default 10).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 Port clk: input, 1 bit, sole clock; all state changes on its rising edge.
REQ-006 Port reset: input, 1 bit, synchronous, active-high.
REQ-007 Port in_valid: input, 1 bit, a result vector is present on in_result.
REQ-008 Port in_result: input, RES_BW bits, packed result vector; channel c occupies bits [c*O_F_BW +: O_F_BW].
REQ-009 Port in_ready: output, 1 bit, block can accept a vector this cycle.
REQ-010 Port out_word: output, 32 bits, current outgoing data word.
REQ-011 Port out_address: output, 32 bits, word index of out_word, 0..NW-1.
REQ-012 Port out_enable: output, 1 bit, out_word and out_address are valid.
REQ-013 Port out_ready: input, 1 bit, downstream accepts the word this cycle.
REQ-014 Port out_done: output, 1 bit, one-cycle pulse after the last word of a vector is accepted.

Function
REQ-015 FSM states: IDLE, SEND, DONE; encoding is free.
REQ-016 IDLE: in_ready=1, out_enable=0; a transfer is accepted when in_valid=1 and in_ready=1.
REQ-017 On acceptance, in_result is captured into an internal (NW*32)-bit shift buffer, bits above RES_BW are zero, the word counter is cleared to 0, and the FSM moves to SEND.
REQ-018 SEND: in_ready=0, out_enable=1, out_word=buffer[31:0], out_address=word counter.
REQ-019 A word is accepted when out_enable=1 and out_ready=1 in the same cycle; on acceptance the buffer shifts right by 32 bits and the counter increments.
REQ-020 When out_ready=0 in SEND, out_word, out_address and out_enable hold unchanged (no word dropped, none duplicated).
REQ-021 On acceptance of the word with address NW-1, the FSM moves to DONE; out_enable is 0 in the following cycle.
REQ-022 DONE lasts exactly one cycle with out_done=1, in_ready=0, out_enable=0, then returns to IDLE.
REQ-023 out_done is 0 in all states except DONE.
REQ-024 Latency: the first word is presented the cycle after acceptance; with out_ready held at 1, a vector takes NW cycles in SEND plus 1 in DONE, so the next vector is accepted no earlier than NW+2 cycles after the previous one.
REQ-025 in_valid and in_result are ignored outside IDLE; no input queue exists.
REQ-026 Word k carries in_result bits [32k+31:32k], zero-filled above RES_BW, so the last word holds the remainder bits in its LSBs.
REQ-027 The counter is wide enough for NW-1 and is zero-extended onto out_address.
REQ-028 NW=1 (RES_BW<=32) is supported: a single SEND word at address 0, then DONE.

Reset
REQ-029 While reset=1 at a clock edge, the FSM goes to IDLE and the counter and buffer clear to 0.
REQ-030 Output values at and after reset: in_ready=1, out_enable=0, out_done=0, out_word=0, out_address=0.
REQ-031 Reset asserted mid-SEND or in DONE aborts the vector on the next edge; no further words and no out_done are produced for it.

Verification
REQ-032 Scenario, single vector: defaults; in_result channel c = c+1; out_ready=1 -> 10 words at addresses 0..9, word0=0x00002_00001 (bits 31:0 = 0x00200001), then out_done pulses once, then in_ready=1.
REQ-033 Scenario, backpressure: out_ready toggles 1,0,0,1,... -> each address appears exactly once with stable data while stalled, and the total word count is 10.
REQ-034 Scenario, ignored input: in_valid=1 with a new vector during SEND -> the output stream is unchanged and the new vector is not captured until IDLE.
REQ-035 Scenario, reset mid-transfer: reset=1 after address 4 is accepted -> next cycle out_enable=0, out_done=0, in_ready=1, and no out_done for that vector.
REQ-036 Scenario, padding: CO=3, O_F_BW=20 (RES_BW=60, NW=2), in_result all ones -> word0=0xFFFFFFFF, word1=0x0FFFFFFF.
REQ-037 Scenario, back-to-back: in_valid held at 1 with out_ready=1 -> the second vector is accepted exactly NW+2 cycles after the first.
